// File: rtl/esm_instr_window.sv
// Out-of-order instruction window feeding the ESM IIM core: fixed slots, an age matrix and a
// registered hazard-free mask; issues the core-selected slot and refills from fetch.
module esm_instr_window #(
    parameter int unsigned bs = 16,
    parameter int unsigned iw = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [iw-1:0]          in_instr,
    output logic                   in_ready,
    input  logic                   issue_en,
    input  logic [$clog2(bs)-1:0]  issue_index,
    output logic [0:bs-1]          independent_instr,
    output logic [iw-1:0]          issue_instr,
    output logic                   issue_out_valid,
    output logic                   issue_err,
    output logic [$clog2(bs):0]    occupancy
);

    localparam int unsigned IdxW = $clog2(bs);
    localparam int unsigned OccW = IdxW + 1;

    logic [bs-1:0]   valid_q, valid_d;
    logic [iw-1:0]   slot_q [bs];
    // older_q[i][j] = 1: slot j entered the window before slot i
    logic [bs-1:0]   older_q [bs];
    logic [bs-1:0]   older_d [bs];
    logic [0:bs-1]   indep_q, indep_d;
    logic [iw-1:0]   issue_instr_q;
    logic            issue_out_valid_q, issue_err_q;
    logic [OccW-1:0] occ_q, occ_d;

    logic [IdxW-1:0] free_idx;
    logic            insert, issue_ok, issue_bad;
    logic [bs-1:0]   issue_onehot;

    // Conservative RV32 field compare; x0 never creates a hazard.
    function automatic logic hazard(input logic [iw-1:0] young, input logic [iw-1:0] old);
        logic [4:0] rd_y, rs1_y, rs2_y, rd_o, rs1_o, rs2_o;
        logic       raw, war, waw;
        rd_y  = young[11:7];
        rs1_y = young[19:15];
        rs2_y = young[24:20];
        rd_o  = old[11:7];
        rs1_o = old[19:15];
        rs2_o = old[24:20];
        raw   = (rd_o != 5'd0) && ((rd_o == rs1_y) || (rd_o == rs2_y));
        war   = (rd_y != 5'd0) && ((rd_y == rs1_o) || (rd_y == rs2_o));
        waw   = (rd_y != 5'd0) && (rd_y == rd_o);
        return raw || war || waw;
    endfunction

    assign in_ready = rst && (occ_q != OccW'(bs));
    assign insert   = in_valid && in_ready;

    assign issue_ok  = issue_en && valid_q[issue_index] && indep_q[issue_index];
    assign issue_bad = issue_en && !issue_ok;

    always_comb begin
        issue_onehot = '0;
        if (issue_ok) begin
            issue_onehot[issue_index] = 1'b1;
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < bs; i++) begin
            indep_d[i] = valid_q[i];
            for (int j = 0; j < bs; j++) begin
                if (valid_q[j] && older_q[i][j] && hazard(slot_q[i], slot_q[j])) begin
                    indep_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < bs; i++) begin
            older_d[i] = older_q[i] & ~issue_onehot;
        end
        valid_d = valid_d & ~issue_onehot;
        if (insert) begin
            valid_d[free_idx] = 1'b1;
            for (int j = 0; j < bs; j++) begin
                older_d[j][free_idx] = 1'b0;
            end
            older_d[free_idx] = valid_q & ~issue_onehot;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (insert && !issue_ok) begin
            occ_d = occ_q + OccW'(1);
        end else if (!insert && issue_ok) begin
            occ_d = occ_q - OccW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q           <= '0;
            indep_q           <= '0;
            issue_instr_q     <= '0;
            issue_out_valid_q <= 1'b0;
            issue_err_q       <= 1'b0;
            occ_q             <= '0;
            for (int i = 0; i < bs; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            valid_q           <= valid_d;
            indep_q           <= indep_d;
            issue_out_valid_q <= issue_ok;
            issue_err_q       <= issue_bad;
            occ_q             <= occ_d;
            for (int i = 0; i < bs; i++) begin
                older_q[i] <= older_d[i];
            end
            if (issue_ok) begin
                issue_instr_q <= slot_q[issue_index];
            end
        end
    end

    // Payload needs no reset: insert is already blocked while rst is low.
    always_ff @(posedge clk) begin
        if (insert) begin
            slot_q[free_idx] <= in_instr;
        end
    end

    assign independent_instr = indep_q;
    assign issue_instr       = issue_instr_q;
    assign issue_out_valid   = issue_out_valid_q;
    assign issue_err         = issue_err_q;
    assign occupancy         = occ_q;

endmodule

// File: tb/tb_esm_instr_window.sv
// Scenario bench for esm_instr_window; issued instructions are checked against a queue of
// expected words pushed when each issue request is driven.
module tb_esm_instr_window;

    localparam int BS = 16;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_instr = '0;
    logic          in_ready;
    logic          issue_en = 1'b0;
    logic [3:0]    issue_index = '0;
    logic [0:BS-1] indep;
    logic [IW-1:0] issue_instr;
    logic          issue_out_valid;
    logic          issue_err;
    logic [4:0]    occupancy;

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [IW-1:0] exp_q [$];
    logic [IW-1:0] exp_w;

    esm_instr_window #(.bs(BS), .iw(IW)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_instr          (in_instr),
        .in_ready          (in_ready),
        .issue_en          (issue_en),
        .issue_index       (issue_index),
        .independent_instr (indep),
        .issue_instr       (issue_instr),
        .issue_out_valid   (issue_out_valid),
        .issue_err         (issue_err),
        .occupancy         (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mk(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), 7'h33};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        issue_en = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic req_issue(input int idx, input logic expect_ok, input logic [IW-1:0] w);
        issue_en = 1'b1;
        issue_index = 4'(idx);
        if (expect_ok) exp_q.push_back(w);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_mis++; $display("FAIL reset_in_ready cyc%0d: got %b want 0", c, in_ready);
            end
            n_cmp++;
            if ({indep, occupancy, issue_out_valid, issue_err} !== '0) begin
                n_mis++;
                $display("FAIL reset_state cyc%0d: mask=%b occ=%0d ov=%b err=%b want all 0",
                         c, indep, occupancy, issue_out_valid, issue_err);
            end
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_mis++; $display("FAIL idle_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if ({indep, occupancy, issue_out_valid, issue_err} !== '0) begin
            n_mis++;
            $display("FAIL idle_state: mask=%b occ=%0d ov=%b err=%b want all 0",
                     indep, occupancy, issue_out_valid, issue_err);
        end
    endtask

    task automatic test_independent();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h002081B3; step();
        in_instr = 32'h00838333; step();
        in_valid = 1'b0; step();
        n_cmp++;
        if (indep[0:1] !== 2'b11 || occupancy !== 5'd2) begin
            n_mis++; $display("FAIL indep_pair: mask01=%b occ=%0d want 11 occ=2", indep[0:1], occupancy);
        end
    endtask

    task automatic test_raw();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h002081B3; step();
        in_instr = 32'h00518233; step();
        in_valid = 1'b0; step();
        n_cmp++;
        if (indep[0:1] !== 2'b10) begin
            n_mis++; $display("FAIL raw_mask: got %b want 10", indep[0:1]);
        end
        req_issue(0, 1'b1, 32'h002081B3);
        step();
        issue_en = 1'b0;
        n_cmp++;
        if (issue_out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_mis++; $display("FAIL raw_issue_valid: got %b want 1", issue_out_valid);
        end else begin
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (issue_instr !== exp_w) begin
                n_mis++; $display("FAIL raw_issue_instr: got %h want %h", issue_instr, exp_w);
            end
        end
        step();
        n_cmp++;
        if (indep[0:1] !== 2'b01 || issue_out_valid !== 1'b0 || occupancy !== 5'd1) begin
            n_mis++;
            $display("FAIL raw_after: mask01=%b ov=%b occ=%0d want 01 0 1",
                     indep[0:1], issue_out_valid, occupancy);
        end
    endtask

    task automatic test_illegal();
        int idxs [2];
        idxs[0] = 1;
        idxs[1] = 7;
        do_reset();
        in_valid = 1'b1; in_instr = 32'h002081B3; step();
        in_instr = 32'h00518233; step();
        in_valid = 1'b0; step();
        for (int k = 0; k < 2; k++) begin
            req_issue(idxs[k], 1'b0, '0);
            step();
            issue_en = 1'b0;
            n_cmp++;
            if (issue_err !== 1'b1 || issue_out_valid !== 1'b0 || occupancy !== 5'd2) begin
                n_mis++;
                $display("FAIL illegal_idx%0d: err=%b ov=%b occ=%0d want 1 0 2",
                         idxs[k], issue_err, issue_out_valid, occupancy);
            end
            step();
            n_cmp++;
            if (issue_err !== 1'b0) begin
                n_mis++; $display("FAIL illegal_err_drop idx%0d: got %b want 0", idxs[k], issue_err);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < BS; i++) begin
            in_valid = 1'b1; in_instr = mk(i + 1, 0, 0); step();
        end
        n_cmp++;
        if (in_ready !== 1'b0 || occupancy !== 5'd16) begin
            n_mis++; $display("FAIL full_state: rdy=%b occ=%0d want 0 16", in_ready, occupancy);
        end
        in_instr = 32'h40000333;
        req_issue(5, 1'b1, mk(6, 0, 0));
        step();
        issue_en = 1'b0;
        n_cmp++;
        if (issue_out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_mis++; $display("FAIL full_issue_valid: got %b want 1", issue_out_valid);
        end else begin
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (issue_instr !== exp_w) begin
                n_mis++; $display("FAIL full_issue_instr: got %h want %h", issue_instr, exp_w);
            end
        end
        n_cmp++;
        if (occupancy !== 5'd15 || in_ready !== 1'b1) begin
            n_mis++; $display("FAIL full_no_insert: occ=%0d rdy=%b want 15 1", occupancy, in_ready);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (occupancy !== 5'd16 || in_ready !== 1'b0) begin
            n_mis++; $display("FAIL full_refill: occ=%0d rdy=%b want 16 0", occupancy, in_ready);
        end
        step();
        n_cmp++;
        if (indep[5] !== 1'b1) begin
            n_mis++; $display("FAIL full_slot5_mask: got %b want 1", indep[5]);
        end
        req_issue(5, 1'b1, 32'h40000333);
        step();
        issue_en = 1'b0;
        n_cmp++;
        if (issue_out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_mis++; $display("FAIL refill_issue_valid: got %b want 1", issue_out_valid);
        end else begin
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (issue_instr !== exp_w) begin
                n_mis++; $display("FAIL refill_slot5_instr: got %h want %h", issue_instr, exp_w);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h002081B3; step();
        in_valid = 1'b0; step();
        in_valid = 1'b1; in_instr = 32'h00838333;
        req_issue(0, 1'b1, 32'h002081B3);
        step();
        in_valid = 1'b0;
        issue_en = 1'b0;
        n_cmp++;
        if (occupancy !== 5'd1) begin
            n_mis++; $display("FAIL b2b_occupancy: got %0d want 1", occupancy);
        end
        n_cmp++;
        if (issue_out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_mis++; $display("FAIL b2b_issue_valid: got %b want 1", issue_out_valid);
        end else begin
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (issue_instr !== exp_w) begin
                n_mis++; $display("FAIL b2b_issue_instr: got %h want %h", issue_instr, exp_w);
            end
        end
        step();
        n_cmp++;
        if (indep[0:1] !== 2'b01) begin
            n_mis++; $display("FAIL b2b_mask: got %b want 01", indep[0:1]);
        end
        req_issue(1, 1'b0, '0);
        rst = 1'b0;
        step();
        issue_en = 1'b0;
        n_cmp++;
        if (issue_out_valid !== 1'b0 || occupancy !== 5'd0 || indep !== '0 || in_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL midreset: ov=%b occ=%0d mask=%b rdy=%b want 0 0 0 0",
                     issue_out_valid, occupancy, indep, in_ready);
        end
        rst = 1'b1;
        req_issue(1, 1'b0, '0);
        step();
        issue_en = 1'b0;
        n_cmp++;
        if (issue_err !== 1'b1 || issue_out_valid !== 1'b0) begin
            n_mis++; $display("FAIL midreset_cleared: err=%b ov=%b want 1 0", issue_err, issue_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw();
        test_illegal();
        test_full();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
